// File: rtl/attack_round_seq.sv
// attack_round_seq: clocked battleship attack-round engine. Latches the ship map at start,
// resolves each confirmed shot once, holds the outcome on the RGB LED and tracks win/loss.
module attack_round_seq #(
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int DATA_WIDTH    = 35,
  parameter int COORD_WIDTH   = 3,
  parameter int MAX_SHOTS     = 20,
  parameter int LED_HOLD      = 25000000,
  parameter int CNT_WIDTH     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  selected_map,
  input  logic [COORD_WIDTH-1:0] x_coord_code,
  input  logic [COORD_WIDTH-1:0] y_coord_code,
  input  logic                   enableAttack,
  input  logic                   confirmAttack,
  input  logic                   show_hits,
  output logic [DATA_WIDTH-1:0]  matriz_data,
  output logic [1:0]             ledRgb,
  output logic [CNT_WIDTH-1:0]   shots_count,
  output logic [CNT_WIDTH-1:0]   hits_count,
  output logic                   game_over,
  output logic                   win,
  output logic                   busy
);

  localparam int IDX_W  = $clog2(DATA_WIDTH);
  localparam int HOLD_W = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;

  localparam logic [HOLD_W-1:0]    HOLD_INIT = HOLD_W'(LED_HOLD - 1);
  localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_SHOTS);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_AIM      = 3'd1;
  localparam logic [2:0] S_RESOLVE  = 3'd2;
  localparam logic [2:0] S_FEEDBACK = 3'd3;
  localparam logic [2:0] S_OVER     = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [2:0]             sync_q, sync_d;
  logic [DATA_WIDTH-1:0]  ship_map_q, ship_map_d;
  logic [DATA_WIDTH-1:0]  shot_map_q, shot_map_d;
  logic [DATA_WIDTH-1:0]  matriz_q, matriz_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_WIDTH-1:0]   shots_q, shots_d, hits_q, hits_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [1:0]             led_rgb_q, led_rgb_d;
  logic                   game_over_q, game_over_d;
  logic                   win_q, win_d;
  logic                   busy_q, busy_d;

  logic                   press_s;
  logic                   coord_ok_s;
  logic [IDX_W-1:0]       cell_idx_s;
  logic [DATA_WIDTH-1:0]  cell_mask_s;
  logic                   already_shot_s;
  logic                   all_hit_s;

  // Falling edge of the synchronized button, one cycle wide.
  assign press_s = sync_q[2] & ~sync_q[1];

  assign coord_ok_s = (x_q != {COORD_WIDTH{1'b0}}) && (32'(x_q) <= 32'(TOTAL_COLUNES)) &&
                      (y_q != {COORD_WIDTH{1'b0}}) && (32'(y_q) <= 32'(COLUNE_SIZE));
  assign cell_idx_s = IDX_W'((32'(TOTAL_COLUNES) - 32'(x_q)) * 32'(COLUNE_SIZE) + 32'(y_q) - 32'd1);
  assign cell_mask_s = coord_ok_s ? (DATA_WIDTH'(1) << cell_idx_s) : {DATA_WIDTH{1'b0}};
  assign already_shot_s = |(shot_map_q & cell_mask_s);
  assign all_hit_s = (ship_map_q != {DATA_WIDTH{1'b0}}) &&
                     ((ship_map_q & ~shot_map_q) == {DATA_WIDTH{1'b0}});

  // Next-state logic for the round FSM, maps, counters and LED feedback.
  always_comb begin
    state_d     = state_q;
    ship_map_d  = ship_map_q;
    shot_map_d  = shot_map_q;
    x_d         = x_q;
    y_d         = y_q;
    shots_d     = shots_q;
    hits_d      = hits_q;
    hold_d      = hold_q;
    led_rgb_d   = led_rgb_q;
    game_over_d = game_over_q;
    win_d       = win_q;
    sync_d      = {sync_q[1:0], confirmAttack};
    if (start) begin
      ship_map_d  = selected_map;
      shot_map_d  = {DATA_WIDTH{1'b0}};
      shots_d     = {CNT_WIDTH{1'b0}};
      hits_d      = {CNT_WIDTH{1'b0}};
      hold_d      = {HOLD_W{1'b0}};
      led_rgb_d   = 2'b00;
      game_over_d = 1'b0;
      win_d       = 1'b0;
      state_d     = S_AIM;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_AIM: begin
          if (press_s && enableAttack) begin
            x_d     = x_coord_code;
            y_d     = y_coord_code;
            state_d = S_RESOLVE;
          end else begin
            state_d = S_AIM;
          end
        end
        S_RESOLVE: begin
          if (!coord_ok_s || already_shot_s || (shots_q >= CNT_MAX)) begin
            led_rgb_d = 2'b11;
          end else if (|(ship_map_q & cell_mask_s)) begin
            shot_map_d = shot_map_q | cell_mask_s;
            shots_d    = shots_q + CNT_ONE;
            hits_d     = hits_q + CNT_ONE;
            led_rgb_d  = 2'b10;
          end else begin
            shot_map_d = shot_map_q | cell_mask_s;
            shots_d    = shots_q + CNT_ONE;
            led_rgb_d  = 2'b01;
          end
          hold_d  = HOLD_INIT;
          state_d = S_FEEDBACK;
        end
        S_FEEDBACK: begin
          if (hold_q == {HOLD_W{1'b0}}) begin
            led_rgb_d = 2'b00;
            // Win is checked first so a winning last shot is never reported as a loss.
            if (all_hit_s) begin
              win_d       = 1'b1;
              game_over_d = 1'b1;
              state_d     = S_OVER;
            end else if (shots_q == CNT_MAX) begin
              win_d       = 1'b0;
              game_over_d = 1'b1;
              state_d     = S_OVER;
            end else begin
              state_d = S_AIM;
            end
          end else begin
            hold_d = hold_q - HOLD_ONE;
          end
        end
        S_OVER: state_d = S_OVER;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d   = (state_d == S_RESOLVE) || (state_d == S_FEEDBACK);
    matriz_d = ~(show_hits ? (shot_map_q & ship_map_q) : shot_map_q);
  end

  // State and output registers; the button synchronizer idles released (high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sync_q      <= 3'b111;
      ship_map_q  <= {DATA_WIDTH{1'b0}};
      shot_map_q  <= {DATA_WIDTH{1'b0}};
      matriz_q    <= {DATA_WIDTH{1'b1}};
      x_q         <= {COORD_WIDTH{1'b0}};
      y_q         <= {COORD_WIDTH{1'b0}};
      shots_q     <= {CNT_WIDTH{1'b0}};
      hits_q      <= {CNT_WIDTH{1'b0}};
      hold_q      <= {HOLD_W{1'b0}};
      led_rgb_q   <= 2'b00;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      ship_map_q  <= ship_map_d;
      shot_map_q  <= shot_map_d;
      matriz_q    <= matriz_d;
      x_q         <= x_d;
      y_q         <= y_d;
      shots_q     <= shots_d;
      hits_q      <= hits_d;
      hold_q      <= hold_d;
      led_rgb_q   <= led_rgb_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
      busy_q      <= busy_d;
    end
  end

  assign matriz_data = matriz_q;
  assign ledRgb      = led_rgb_q;
  assign shots_count = shots_q;
  assign hits_count  = hits_q;
  assign game_over   = game_over_q;
  assign win         = win_q;
  assign busy        = busy_q;

endmodule

// File: doc/attack_round_seq.md
# attack_round_seq

Clocked, parametrised attack-round engine for the battleship game. It latches the defending player's ship map at round start and keeps a registered shot map of every attacked cell. Each confirmed shot is resolved once as hit, miss or rejected, and the result is held on the RGB LED for a programmable time. It also counts shots and hits and flags win or loss. It sits between the coordinate/button input logic and the LED matrix driver, and it replaces the combinational, button-clocked attack path.

## Interface
- COLUNE_SIZE, 7: cells per column (y range).
- TOTAL_COLUNES, 5: number of columns (x range).
- DATA_WIDTH, 35: map width; must equal COLUNE_SIZE*TOTAL_COLUNES.
- COORD_WIDTH, 3: width of each coordinate code.
- MAX_SHOTS, 20: shot budget per round (1..2^CNT_WIDTH-1).
- LED_HOLD, 25000000: feedback hold time in clock cycles (>=1).
- CNT_WIDTH, 6: width of the shot and hit counters (>= clog2(DATA_WIDTH+1)).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  synchronous pulse; loads selected_map and clears the round.
- selected_map  in  DATA_WIDTH  ship map; 1 = ship cell.
- x_coord_code  in  COORD_WIDTH  column code, valid 1..TOTAL_COLUNES.
- y_coord_code  in  COORD_WIDTH  row code, valid 1..COLUNE_SIZE.
- enableAttack  in  1  attack phase enable; when low, presses are ignored.
- confirmAttack  in  1  raw push-button, active-low.
- show_hits  in  1  display mode: 0 shows all shots, 1 shows hits only.
- matriz_data  out  DATA_WIDTH  active-low matrix image; 0 = lit.
- ledRgb  out  2  [1] red = hit, [0] green = miss, both = rejected.
- shots_count  out  CNT_WIDTH  accepted shots this round.
- hits_count  out  CNT_WIDTH  distinct ship cells hit.
- game_over  out  1  round finished.
- win  out  1  all ship cells hit; valid while game_over = 1.
- busy  out  1  high in RESOLVE and FEEDBACK.

## Operation
- Cell index for (x, y) is (TOTAL_COLUNES-x)*COLUNE_SIZE + (y-1). Column code 1 maps to the MSB column.
- A code is invalid if x = 0, x > TOTAL_COLUNES, y = 0 or y > COLUNE_SIZE.
- confirmAttack passes through a 2-flop synchronizer. A press is one cycle of falling-edge detect on the synchronized signal.
- State machine states: IDLE, AIM, RESOLVE, FEEDBACK, OVER.
  - IDLE: wait for start.
  - start, in any state: ship_map <= selected_map, shot_map <= 0, counters <= 0, game_over/win <= 0, ledRgb <= 00, next state AIM.
  - AIM: a press with enableAttack = 1 latches the coordinates and moves to RESOLVE. Presses with enableAttack = 0 are dropped.
  - RESOLVE (1 cycle):
    - Invalid coordinate, or cell already shot: outcome = rejected. Maps and counters are unchanged.
    - Otherwise: set the shot_map bit and increment shots_count. If the ship bit is 1, increment hits_count and set outcome = hit; else outcome = miss.
    - Always go to FEEDBACK.
  - FEEDBACK: ledRgb shows the outcome for exactly LED_HOLD cycles, then returns to 00.
    - If (ship_map & ~shot_map) == 0 and ship_map != 0: win = 1, game_over = 1, next state OVER.
    - Else if shots_count == MAX_SHOTS: game_over = 1, win = 0, next state OVER.
    - Else: next state AIM.
    - Win takes precedence when the last shot both wins and exhausts the budget.
    - Presses during FEEDBACK are discarded, not queued.
    - Deasserting enableAttack does not shorten FEEDBACK.
- OVER: hold all outputs; only start or reset leave this state.
- An all-zero ship map never wins; the round ends only by exhausting the shot budget.
- matriz_data = ~(show_hits ? (shot_map & ship_map) : shot_map), registered.
- Counters never wrap: rejected shots are not counted, and MAX_SHOTS caps shots_count.

## Timing
- Reset values: state IDLE, ship_map = 0, shot_map = 0, matriz_data = all ones, ledRgb = 00, shots_count = 0, hits_count = 0, game_over = 0, win = 0, busy = 0. Synchronizer flops reset to 1 (button released).
- Press latency: raw falling edge at cycle N → press detected at cycle N+2 → RESOLVE at N+3 → maps, counters and ledRgb updated at N+4 → ledRgb returns to 00 at N+4+LED_HOLD.
- matriz_data follows shot_map with one register of delay.
- show_hits takes effect on matriz_data one cycle after it changes.
- start is sampled every cycle and overrides any press in the same cycle.
- Reset asserted mid-round clears everything immediately; there is no partial update.

## Test plan
- Reset, then start with selected_map = 35'h4_0000_0001, then press at x=5, y=1 → ledRgb = 10 for LED_HOLD cycles, hits_count = 1, shots_count = 1, matriz_data[0] = 0.
- Press at x=1, y=7 (bit 34 set) then x=2, y=1 with a map of bits 34 and 0 → first press hit, second press miss (ledRgb = 01). After also hitting x=5, y=1: win = 1, game_over = 1.
- Repeat the same coordinate, and press at x=0 or y=7 with x=6 → ledRgb = 11, counters unchanged, shot_map unchanged.
- MAX_SHOTS = 3, all misses → game_over = 1, win = 0 after the third FEEDBACK. A fourth press is ignored in OVER.
- Press with enableAttack = 0, then a second press during FEEDBACK → no state change for either; shots_count increments only for the legitimate press.
- Assert reset during FEEDBACK, then issue start mid-round → all outputs return to reset values, then the round is cleared with the new map loaded. Toggle show_hits and confirm the matrix shows shot_map & ship_map.
